// File: rtl/coproc_axi_master.sv
//==============================================================================
// Module   : coproc_axi_master
// Purpose  : Upstream driver for the arithmetic coprocessor's AXI4-Lite slave.
//            Takes one command (num1, num2, instruction), writes the three
//            operand registers, polls the status register until ready or
//            MAX_POLLS reads have been made, then reads the result back and
//            presents it on a response valid/ready interface.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   cmd_valid/cmd_ready        command handshake
//   cmd_num1/num2/instruction  command payload
//   rsp_valid/rsp_ready        response handshake
//   rsp_result, rsp_timeout    response payload (result invalid on timeout)
//   axi_aw*/axi_w*/axi_b*      AXI4-Lite write channels
//   axi_ar*/axi_r*             AXI4-Lite read channels
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module coproc_axi_master #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_POLLS = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_num1,
  input  logic [31:0] cmd_num2,
  input  logic [1:0]  cmd_instruction,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_timeout,
  output logic [31:0] axi_awaddr,
  output logic        axi_awvalid,
  input  logic        axi_awready,
  output logic [31:0] axi_wdata,
  output logic        axi_wvalid,
  input  logic        axi_wready,
  input  logic        axi_bvalid,
  output logic        axi_bready,
  output logic [31:0] axi_araddr,
  output logic        axi_arvalid,
  input  logic        axi_arready,
  input  logic [31:0] axi_rdata,
  input  logic        axi_rvalid,
  output logic        axi_rready
);

  typedef enum logic [2:0] {
    S_IDLE         = 3'd0,
    S_WR_ADDR_DATA = 3'd1,
    S_WR_RESP      = 3'd2,
    S_RD_ADDR      = 3'd3,
    S_RD_DATA      = 3'd4,
    S_RESP         = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    STEP_NUM1   = 3'd0,
    STEP_NUM2   = 3'd1,
    STEP_INSTR  = 3'd2,
    STEP_STATUS = 3'd3,
    STEP_RESULT = 3'd4
  } step_t;

  localparam logic [31:0] c_OFF_NUM1   = 32'h0000_0000;
  localparam logic [31:0] c_OFF_NUM2   = 32'h0000_0004;
  localparam logic [31:0] c_OFF_INSTR  = 32'h0000_0008;
  localparam logic [31:0] c_OFF_STATUS = 32'h0000_000C;
  localparam logic [31:0] c_OFF_RESULT = 32'h0000_0010;
  localparam logic [7:0]  c_MAX_POLLS  = 8'(MAX_POLLS);

  state_t      r_state;
  state_t      w_next;
  step_t       r_step;
  logic [31:0] r_num1;
  logic [31:0] r_num2;
  logic [1:0]  r_instr;
  logic [7:0]  r_polls;
  logic        r_aw_done;
  logic        r_w_done;
  logic [31:0] r_rsp_result;
  logic        r_rsp_timeout;

  logic        w_aw_pending;
  logic        w_w_pending;
  logic        w_aw_fire;
  logic        w_w_fire;
  logic        w_wr_done;
  logic [7:0]  w_polls_next;
  logic        w_poll_last;
  logic [31:0] w_wr_offset;
  logic [31:0] w_wr_data;
  logic [31:0] w_rd_offset;

  // AW and W are tracked separately so each valid can drop on its own.
  assign w_aw_pending = (r_state == S_WR_ADDR_DATA) && !r_aw_done;
  assign w_w_pending  = (r_state == S_WR_ADDR_DATA) && !r_w_done;
  assign w_aw_fire    = w_aw_pending && axi_awready;
  assign w_w_fire     = w_w_pending && axi_wready;
  // Both handshakes done, counting one that completes this very cycle.
  assign w_wr_done    = (r_aw_done || w_aw_fire) && (r_w_done || w_w_fire);

  assign w_polls_next = r_polls + 8'd1;
  assign w_poll_last  = (w_polls_next == c_MAX_POLLS);

  always_comb begin
    w_wr_offset = c_OFF_INSTR;
    w_wr_data   = {30'd0, r_instr};
    case (r_step)
      STEP_NUM1: begin
        w_wr_offset = c_OFF_NUM1;
        w_wr_data   = r_num1;
      end
      STEP_NUM2: begin
        w_wr_offset = c_OFF_NUM2;
        w_wr_data   = r_num2;
      end
      default: ;
    endcase
  end

  assign w_rd_offset = (r_step == STEP_RESULT) ? c_OFF_RESULT : c_OFF_STATUS;

  // cmd_ready is masked by reset so it is low while reset is held.
  assign cmd_ready   = (r_state == S_IDLE) && !reset;
  assign rsp_result  = r_rsp_result;
  assign rsp_timeout = r_rsp_timeout;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    axi_awvalid = 1'b0;
    axi_wvalid  = 1'b0;
    axi_bready  = 1'b0;
    axi_arvalid = 1'b0;
    axi_rready  = 1'b0;
    axi_awaddr  = 32'd0;
    axi_wdata   = 32'd0;
    axi_araddr  = 32'd0;
    rsp_valid   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cmd_valid) w_next = S_WR_ADDR_DATA;
      end
      S_WR_ADDR_DATA: begin
        axi_awvalid = w_aw_pending;
        axi_wvalid  = w_w_pending;
        axi_awaddr  = BASE_ADDR + w_wr_offset;
        axi_wdata   = w_wr_data;
        if (w_wr_done) w_next = S_WR_RESP;
      end
      S_WR_RESP: begin
        axi_bready = 1'b1;
        if (axi_bvalid) begin
          w_next = (r_step == STEP_INSTR) ? S_RD_ADDR : S_WR_ADDR_DATA;
        end
      end
      S_RD_ADDR: begin
        axi_arvalid = 1'b1;
        axi_araddr  = BASE_ADDR + w_rd_offset;
        if (axi_arready) w_next = S_RD_DATA;
      end
      S_RD_DATA: begin
        axi_rready = 1'b1;
        if (axi_rvalid) begin
          if (r_step == STEP_RESULT) begin
            w_next = S_RESP;
          end else if (!axi_rdata[0] && w_poll_last) begin
            w_next = S_RESP;
          end else begin
            w_next = S_RD_ADDR;
          end
        end
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_step        <= STEP_NUM1;
      r_num1        <= 32'd0;
      r_num2        <= 32'd0;
      r_instr       <= 2'd0;
      r_polls       <= 8'd0;
      r_aw_done     <= 1'b0;
      r_w_done      <= 1'b0;
      r_rsp_result  <= 32'd0;
      r_rsp_timeout <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_num1  <= cmd_num1;
            r_num2  <= cmd_num2;
            r_instr <= cmd_instruction;
            r_step  <= STEP_NUM1;
            r_polls <= 8'd0;
          end
        end
        S_WR_ADDR_DATA: begin
          if (w_wr_done) begin
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
          end else begin
            r_aw_done <= r_aw_done || w_aw_fire;
            r_w_done  <= r_w_done || w_w_fire;
          end
        end
        S_WR_RESP: begin
          if (axi_bvalid) begin
            case (r_step)
              STEP_NUM1: r_step <= STEP_NUM2;
              STEP_NUM2: r_step <= STEP_INSTR;
              default:   r_step <= STEP_STATUS;
            endcase
          end
        end
        S_RD_DATA: begin
          if (axi_rvalid) begin
            if (r_step == STEP_RESULT) begin
              r_rsp_result  <= axi_rdata;
              r_rsp_timeout <= 1'b0;
            end else if (axi_rdata[0]) begin
              r_step <= STEP_RESULT;
            end else begin
              r_polls <= w_polls_next;
              if (w_poll_last) begin
                r_rsp_timeout <= 1'b1;
                r_rsp_result  <= 32'd0;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_coproc_axi_master.sv
//==============================================================================
// Module   : tb_coproc_axi_master
// Purpose  : Directed bench for coproc_axi_master. Two instances share one
//            AXI4-Lite slave model through a select mux: instance A uses the
//            default parameters, instance B uses MAX_POLLS=4 and a non-zero
//            BASE_ADDR.
// Revision : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_coproc_axi_master;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sel = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [31:0] cmd_num1 = 32'd0;
  logic [31:0] cmd_num2 = 32'd0;
  logic [1:0]  cmd_instruction = 2'd0;
  logic        rsp_ready = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Per-instance outputs
  logic        a_cmd_ready, a_rsp_valid, a_rsp_timeout, a_awvalid, a_wvalid, a_bready, a_arvalid, a_rready;
  logic [31:0] a_rsp_result, a_awaddr, a_wdata, a_araddr;
  logic        b_cmd_ready, b_rsp_valid, b_rsp_timeout, b_awvalid, b_wvalid, b_bready, b_arvalid, b_rready;
  logic [31:0] b_rsp_result, b_awaddr, b_wdata, b_araddr;

  // Selected master view
  logic        m_cmd_ready, m_rsp_valid, m_rsp_timeout, m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready;
  logic [31:0] m_rsp_result, m_awaddr, m_wdata, m_araddr;

  assign m_cmd_ready   = sel ? b_cmd_ready   : a_cmd_ready;
  assign m_rsp_valid   = sel ? b_rsp_valid   : a_rsp_valid;
  assign m_rsp_timeout = sel ? b_rsp_timeout : a_rsp_timeout;
  assign m_rsp_result  = sel ? b_rsp_result  : a_rsp_result;
  assign m_awvalid     = sel ? b_awvalid     : a_awvalid;
  assign m_awaddr      = sel ? b_awaddr      : a_awaddr;
  assign m_wvalid      = sel ? b_wvalid      : a_wvalid;
  assign m_wdata       = sel ? b_wdata       : a_wdata;
  assign m_bready      = sel ? b_bready      : a_bready;
  assign m_arvalid     = sel ? b_arvalid     : a_arvalid;
  assign m_araddr      = sel ? b_araddr      : a_araddr;
  assign m_rready      = sel ? b_rready      : a_rready;

  // Slave model
  logic        slv_clr = 1'b1;
  int          aw_delay = 0;
  int          not_ready_n = 0;
  logic [31:0] result_val = 32'd0;

  logic [31:0] aw_log [16];
  logic [31:0] w_log  [16];
  logic [31:0] ar_log [16];
  int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt, st_cnt, res_cnt, aw_wait;
  int awv_cycles, wv_cycles, overlap, aw_unstable;
  logic        aw_prev_hold;
  logic [31:0] aw_prev_addr;

  logic        s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
  logic [31:0] s_rdata, cur_addr;

  assign s_awready = (aw_wait >= aw_delay);
  assign s_wready  = 1'b1;
  assign s_arready = 1'b1;
  assign s_bvalid  = (aw_cnt > b_cnt) && (w_cnt > b_cnt);
  assign s_rvalid  = (ar_cnt > r_cnt);
  assign cur_addr  = ar_log[r_cnt % 16];

  always_comb begin
    s_rdata = result_val;
    if (cur_addr[7:0] == 8'h0C) s_rdata = (st_cnt >= not_ready_n) ? 32'h0000_0001 : 32'hFFFF_FFFE;
  end

  always @(posedge clk) begin
    if (slv_clr) begin
      aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0; ar_cnt <= 0; r_cnt <= 0;
      st_cnt <= 0; res_cnt <= 0; aw_wait <= 0;
      awv_cycles <= 0; wv_cycles <= 0; overlap <= 0; aw_unstable <= 0;
      aw_prev_hold <= 1'b0; aw_prev_addr <= 32'd0;
    end else begin
      if (m_awvalid) awv_cycles <= awv_cycles + 1;
      if (m_wvalid) wv_cycles <= wv_cycles + 1;
      if (m_awvalid && m_arvalid) overlap <= overlap + 1;
      if (aw_prev_hold && m_awvalid && (m_awaddr !== aw_prev_addr)) aw_unstable <= aw_unstable + 1;
      aw_prev_hold <= m_awvalid && !s_awready;
      aw_prev_addr <= m_awaddr;
      if (m_awvalid && s_awready) begin
        if (aw_cnt < 16) aw_log[aw_cnt] <= m_awaddr;
        aw_cnt  <= aw_cnt + 1;
        aw_wait <= 0;
      end else if (m_awvalid) begin
        aw_wait <= aw_wait + 1;
      end
      if (m_wvalid && s_wready) begin
        if (w_cnt < 16) w_log[w_cnt] <= m_wdata;
        w_cnt <= w_cnt + 1;
      end
      if (s_bvalid && m_bready) b_cnt <= b_cnt + 1;
      if (m_arvalid && s_arready) begin
        if (ar_cnt < 16) ar_log[ar_cnt] <= m_araddr;
        ar_cnt <= ar_cnt + 1;
      end
      if (s_rvalid && m_rready) begin
        r_cnt <= r_cnt + 1;
        if (cur_addr[7:0] == 8'h0C) st_cnt <= st_cnt + 1;
        else res_cnt <= res_cnt + 1;
      end
    end
  end

  coproc_axi_master #(.BASE_ADDR(32'h0000_0000), .MAX_POLLS(255)) u_dut_a (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid && !sel), .cmd_ready(a_cmd_ready),
    .cmd_num1(cmd_num1), .cmd_num2(cmd_num2), .cmd_instruction(cmd_instruction),
    .rsp_valid(a_rsp_valid), .rsp_ready(rsp_ready && !sel),
    .rsp_result(a_rsp_result), .rsp_timeout(a_rsp_timeout),
    .axi_awaddr(a_awaddr), .axi_awvalid(a_awvalid), .axi_awready(s_awready && !sel),
    .axi_wdata(a_wdata), .axi_wvalid(a_wvalid), .axi_wready(s_wready && !sel),
    .axi_bvalid(s_bvalid && !sel), .axi_bready(a_bready),
    .axi_araddr(a_araddr), .axi_arvalid(a_arvalid), .axi_arready(s_arready && !sel),
    .axi_rdata(s_rdata), .axi_rvalid(s_rvalid && !sel), .axi_rready(a_rready)
  );

  coproc_axi_master #(.BASE_ADDR(32'h4000_0000), .MAX_POLLS(4)) u_dut_b (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid && sel), .cmd_ready(b_cmd_ready),
    .cmd_num1(cmd_num1), .cmd_num2(cmd_num2), .cmd_instruction(cmd_instruction),
    .rsp_valid(b_rsp_valid), .rsp_ready(rsp_ready && sel),
    .rsp_result(b_rsp_result), .rsp_timeout(b_rsp_timeout),
    .axi_awaddr(b_awaddr), .axi_awvalid(b_awvalid), .axi_awready(s_awready && sel),
    .axi_wdata(b_wdata), .axi_wvalid(b_wvalid), .axi_wready(s_wready && sel),
    .axi_bvalid(s_bvalid && sel), .axi_bready(b_bready),
    .axi_araddr(b_araddr), .axi_arvalid(b_arvalid), .axi_arready(s_arready && sel),
    .axi_rdata(s_rdata), .axi_rvalid(s_rvalid && sel), .axi_rready(b_rready)
  );

  // ---------------- stimulus helpers (no checking inside) ----------------
  task automatic slave_clear();
    @(negedge clk);
    slv_clr = 1'b1;
    @(posedge clk);
    #1 slv_clr = 1'b0;
  endtask

  task automatic send_cmd(input logic [31:0] n1, input logic [31:0] n2, input logic [1:0] ins);
    int guard = 0;
    @(negedge clk);
    while (!m_cmd_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    cmd_num1 = n1;
    cmd_num2 = n2;
    cmd_instruction = ins;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  // Returns cycles from the current sample point to rsp_valid, or -1.
  task automatic wait_rsp(output int lat);
    lat = 0;
    while (!m_rsp_valid && lat < 500) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!m_rsp_valid) lat = -1;
  endtask

  task automatic rsp_handshake();
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [5:0] v;
    reset = 1'b1;
    slv_clr = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    v = {a_awvalid, a_wvalid, a_bready, a_arvalid, a_rready, a_rsp_valid};
    checks++;
    if (v !== 6'b0) begin errors++; $display("FAIL reset_valids: got %b expected 000000", v); end
    checks++;
    if (a_cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_cmd_ready: got %b expected 0", a_cmd_ready); end
    checks++;
    if ({a_awaddr, a_wdata, a_araddr, a_rsp_result, a_rsp_timeout} !== 129'd0) begin
      errors++; $display("FAIL reset_data: awaddr %h wdata %h araddr %h result %h timeout %b expected all 0",
                        a_awaddr, a_wdata, a_araddr, a_rsp_result, a_rsp_timeout);
    end
    reset = 1'b0;
    slv_clr = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (a_cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_release_cmd_ready: got %b expected 1", a_cmd_ready); end
  endtask

  task automatic test_basic();
    int lat;
    sel = 1'b0; aw_delay = 0; not_ready_n = 0; result_val = 32'd8;
    slave_clear();
    send_cmd(32'd5, 32'd3, 2'd0);
    wait_rsp(lat);
    checks++;
    if (lat !== 10) begin errors++; $display("FAIL basic_latency: got %0d expected 10", lat); end
    checks++;
    if (m_rsp_result !== 32'd8 || m_rsp_timeout !== 1'b0) begin
      errors++; $display("FAIL basic_result: got %h/%b expected 00000008/0", m_rsp_result, m_rsp_timeout);
    end
    checks++;
    if (aw_cnt !== 3 || aw_log[0] !== 32'h0 || aw_log[1] !== 32'h4 || aw_log[2] !== 32'h8) begin
      errors++; $display("FAIL basic_awaddr: cnt %0d addrs %h %h %h expected 3 0 4 8", aw_cnt, aw_log[0], aw_log[1], aw_log[2]);
    end
    checks++;
    if (w_cnt !== 3 || w_log[0] !== 32'd5 || w_log[1] !== 32'd3 || w_log[2] !== 32'd0) begin
      errors++; $display("FAIL basic_wdata: cnt %0d data %h %h %h expected 3 5 3 0", w_cnt, w_log[0], w_log[1], w_log[2]);
    end
    checks++;
    if (st_cnt !== 1 || res_cnt !== 1 || ar_log[0] !== 32'hC || ar_log[1] !== 32'h10) begin
      errors++; $display("FAIL basic_reads: status %0d result %0d addrs %h %h expected 1 1 c 10", st_cnt, res_cnt, ar_log[0], ar_log[1]);
    end
    checks++;
    if (overlap !== 0) begin errors++; $display("FAIL basic_aw_ar_overlap: got %0d expected 0", overlap); end
    rsp_handshake();
    checks++;
    if (m_rsp_valid !== 1'b0 || m_cmd_ready !== 1'b1) begin
      errors++; $display("FAIL basic_rsp_done: rsp_valid %b cmd_ready %b expected 0 1", m_rsp_valid, m_cmd_ready);
    end
  endtask

  task automatic test_aw_delay();
    int lat;
    sel = 1'b0; aw_delay = 2; not_ready_n = 0; result_val = 32'h33;
    slave_clear();
    send_cmd(32'h1111_1111, 32'h2222_2222, 2'd3);
    wait_rsp(lat);
    checks++;
    if (lat < 0 || m_rsp_result !== 32'h33) begin
      errors++; $display("FAIL awdly_result: lat %0d result %h expected 00000033", lat, m_rsp_result);
    end
    checks++;
    if (awv_cycles !== 9 || wv_cycles !== 3) begin
      errors++; $display("FAIL awdly_valid_cycles: aw %0d w %0d expected 9 3", awv_cycles, wv_cycles);
    end
    checks++;
    if (aw_unstable !== 0) begin errors++; $display("FAIL awdly_addr_stable: got %0d changes expected 0", aw_unstable); end
    checks++;
    if (b_cnt !== 3 || aw_cnt !== 3 || w_cnt !== 3) begin
      errors++; $display("FAIL awdly_handshakes: b %0d aw %0d w %0d expected 3 3 3", b_cnt, aw_cnt, w_cnt);
    end
    checks++;
    if (w_log[2] !== 32'h3 || aw_log[2] !== 32'h8) begin
      errors++; $display("FAIL awdly_instr_write: addr %h data %h expected 8 3", aw_log[2], w_log[2]);
    end
    rsp_handshake();
    aw_delay = 0;
  endtask

  task automatic test_poll();
    int lat;
    sel = 1'b0; aw_delay = 0; not_ready_n = 4; result_val = 32'hFFFF_FFF0;
    slave_clear();
    send_cmd(32'd7, 32'd9, 2'd1);
    wait_rsp(lat);
    checks++;
    if (lat < 0 || st_cnt !== 5 || res_cnt !== 1) begin
      errors++; $display("FAIL poll_counts: lat %0d status %0d result %0d expected 5 1", lat, st_cnt, res_cnt);
    end
    checks++;
    if (m_rsp_result !== 32'hFFFF_FFF0 || m_rsp_timeout !== 1'b0) begin
      errors++; $display("FAIL poll_result: got %h/%b expected fffffff0/0", m_rsp_result, m_rsp_timeout);
    end
    rsp_handshake();
  endtask

  task automatic test_timeout();
    int lat;
    sel = 1'b1; aw_delay = 0; not_ready_n = 1000; result_val = 32'h1234_5678;
    slave_clear();
    send_cmd(32'd1, 32'd2, 2'd2);
    wait_rsp(lat);
    checks++;
    if (lat < 0 || st_cnt !== 4 || res_cnt !== 0) begin
      errors++; $display("FAIL timeout_counts: lat %0d status %0d result %0d expected 4 0", lat, st_cnt, res_cnt);
    end
    checks++;
    if (m_rsp_timeout !== 1'b1 || m_rsp_result !== 32'd0) begin
      errors++; $display("FAIL timeout_rsp: got %h/%b expected 00000000/1", m_rsp_result, m_rsp_timeout);
    end
    checks++;
    if (aw_log[0] !== 32'h4000_0000 || aw_log[2] !== 32'h4000_0008 || ar_log[3] !== 32'h4000_000C) begin
      errors++; $display("FAIL timeout_base_addr: aw0 %h aw2 %h ar3 %h expected 40000000 40000008 4000000c", aw_log[0], aw_log[2], ar_log[3]);
    end
    rsp_handshake();
    sel = 1'b0;
  endtask

  task automatic test_back_to_back();
    int lat, bad, guard;
    logic [31:0] held;
    sel = 1'b0; aw_delay = 0; not_ready_n = 0; result_val = 32'hABCD_0001;
    slave_clear();
    @(negedge clk);
    guard = 0;
    while (!m_cmd_ready && guard < 100) begin @(negedge clk); guard++; end
    cmd_num1 = 32'd1; cmd_num2 = 32'd1; cmd_instruction = 2'd0; cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    wait_rsp(lat);
    held = m_rsp_result;
    cmd_num1 = 32'd10; cmd_num2 = 32'd20;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (m_rsp_valid !== 1'b1 || m_rsp_result !== held || m_rsp_timeout !== 1'b0 || m_cmd_ready !== 1'b0) bad++;
    end
    checks++;
    if (lat < 0 || held !== 32'hABCD_0001) begin
      errors++; $display("FAIL b2b_first_result: lat %0d result %h expected abcd0001", lat, held);
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL b2b_hold_stable: got %0d bad cycles expected 0", bad); end
    checks++;
    if (aw_cnt !== 3) begin errors++; $display("FAIL b2b_no_early_accept: got %0d writes expected 3", aw_cnt); end
    result_val = 32'hABCD_0002;
    rsp_handshake();
    checks++;
    if (m_cmd_ready !== 1'b1 || m_rsp_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_idle_after_rsp: cmd_ready %b rsp_valid %b expected 1 0", m_cmd_ready, m_rsp_valid);
    end
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    wait_rsp(lat);
    checks++;
    if (lat < 0 || m_rsp_result !== 32'hABCD_0002 || w_log[3] !== 32'd10 || w_log[4] !== 32'd20) begin
      errors++; $display("FAIL b2b_second_cmd: lat %0d result %h w3 %h w4 %h expected abcd0002 a 14",
                         lat, m_rsp_result, w_log[3], w_log[4]);
    end
    rsp_handshake();
  endtask

  task automatic test_reset_mid();
    int lat, guard;
    logic [5:0] v;
    sel = 1'b0; aw_delay = 0; not_ready_n = 1000; result_val = 32'h55;
    slave_clear();
    send_cmd(32'd4, 32'd4, 2'd0);
    guard = 0;
    while (st_cnt < 1 && guard < 200) begin
      @(posedge clk);
      #1;
      guard++;
    end
    checks++;
    if (st_cnt !== 1 || m_arvalid !== 1'b1) begin
      errors++; $display("FAIL rstmid_second_poll: status %0d arvalid %b expected 1 1", st_cnt, m_arvalid);
    end
    reset = 1'b1;
    slv_clr = 1'b1;
    @(posedge clk);
    #1;
    v = {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, m_rsp_valid};
    checks++;
    if (v !== 6'b0 || m_cmd_ready !== 1'b0) begin
      errors++; $display("FAIL rstmid_valids: got %b cmd_ready %b expected 000000 0", v, m_cmd_ready);
    end
    reset = 1'b0;
    slv_clr = 1'b0;
    not_ready_n = 0;
    @(posedge clk);
    #1;
    checks++;
    if (m_cmd_ready !== 1'b1) begin errors++; $display("FAIL rstmid_cmd_ready: got %b expected 1", m_cmd_ready); end
    send_cmd(32'd2, 32'd2, 2'd0);
    wait_rsp(lat);
    checks++;
    if (lat !== 10 || m_rsp_result !== 32'h55 || m_rsp_timeout !== 1'b0 || st_cnt !== 1) begin
      errors++; $display("FAIL rstmid_fresh_cmd: lat %0d result %h timeout %b status %0d expected 10 55 0 1",
                         lat, m_rsp_result, m_rsp_timeout, st_cnt);
    end
    rsp_handshake();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_aw_delay();
    test_poll();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, errors so far %0d", errors);
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
